// File: rtl/ysyx_22050133_radix2_divider.sv
// ysyx_22050133_radix2_divider: restoring radix-2 integer divider for RV64 DIV/REM and word variants.
module ysyx_22050133_radix2_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r;
    logic            neg_q, neg_r, word;
    logic [XLEN-1:0] a, b, abs_a, abs_b, ovf_q, zero_r;
    logic            sa, sb, div_zero, ovf;
    logic [XLEN:0]   shifted, trial;
    logic            ge;
    logic [XLEN-1:0] next_q, next_r, q_fix, r_fix, q_out, r_out;
    always_comb begin
        a = divw ? {{(XLEN-32){div_signed & dividend[31]}}, dividend[31:0]} : dividend;
        b = divw ? {{(XLEN-32){div_signed & divisor[31]}}, divisor[31:0]} : divisor;
        sa = div_signed & a[XLEN-1];
        sb = div_signed & b[XLEN-1];
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
        div_zero = b == '0;
        ovf = div_signed & (divw ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == 32'hFFFF_FFFF)
                                 : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
        ovf_q = divw ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
        zero_r = divw ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
        // One restoring step: shift in the next dividend bit, subtract if it fits
        shifted = {rem_r, quo_r[XLEN-1]};
        trial = shifted - {1'b0, dvs_r};
        ge = ~trial[XLEN];
        next_q = {quo_r[XLEN-2:0], ge};
        next_r = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        q_fix = neg_q ? -next_q : next_q;
        r_fix = neg_r ? -next_r : next_r;
        q_out = word ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
        r_out = word ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            word      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (div_valid && !flush) begin
                    word      <= divw;
                    neg_q     <= sa ^ sb;
                    neg_r     <= sa;
                    dvs_r     <= abs_b;
                    rem_r     <= '0;
                    // Word ops start with the 32-bit magnitude in the top half so 32 steps suffice
                    quo_r     <= divw ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                    div_ready <= 1'b0;
                    if (div_zero || ovf) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= div_zero ? '1 : ovf_q;
                        remainder <= div_zero ? zero_r : '0;
                    end else begin
                        state <= CALC;
                        cnt   <= divw ? 7'd32 : 7'd64;
                    end
                end
                CALC: if (flush) begin
                    state     <= IDLE;
                    div_ready <= 1'b1;
                end else begin
                    rem_r <= next_r;
                    quo_r <= next_q;
                    cnt   <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_out;
                        remainder <= r_out;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    div_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050133_radix2_divider.sv
// tb_ysyx_22050133_radix2_divider: directed checks of latency, results, bypasses, flush and reset.
module tb_ysyx_22050133_radix2_divider;
    logic        clk = 1'b0;
    logic        rst, flush, div_valid, divw, div_signed;
    logic [63:0] dividend, divisor;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;
    int          n_tests = 0;
    int          n_fail = 0;

    ysyx_22050133_radix2_divider #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .divw(divw),
        .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
        .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the divider idle; returns #1 after the edge following DONE
    task automatic run(input string tag, input logic w, input logic s, input logic [63:0] a,
                       input logic [63:0] b, input int lat, input logic [63:0] eq, input logic [63:0] er);
        int got = 0;
        logic rdy_seen = 1'b0;
        divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
        step();
        div_valid = 1'b0; dividend = ~a; divisor = ~b; divw = ~w; div_signed = ~s;
        for (int c = 1; c <= 100; c++) begin
            if (div_ready) rdy_seen = 1'b1;
            if (out_valid) begin
                got = c;
                break;
            end
            step();
        end
        chk({tag, " latency"}, 64'(got), 64'(lat));
        chk({tag, " ready_low"}, 64'(rdy_seen), 64'd0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        step();
        chk({tag, " pulse"}, 64'(out_valid), 64'd0);
        chk({tag, " ready_back"}, 64'(div_ready), 64'd1);
        chk({tag, " hold_q"}, quotient, eq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1; flush = 1'b0; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
        dividend = '0; divisor = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst ready", 64'(div_ready), 64'd1);
        chk("rst valid", 64'(out_valid), 64'd0);
        chk("rst q", quotient, 64'd0);
        chk("rst r", remainder, 64'd0);
        step();
        rst = 1'b1;

        run("u100/7", 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2);
        run("s-7/2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run("s20/-3", 1'b0, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2);
        run("umax/2", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        run("wovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        run("ovf64", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 64'd0);
        run("div0", 1'b0, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        run("wdiv0", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFFB, 64'h0000_0001_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
        run("uw_fffe/1", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        run("sw-20/3", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'h0000_0000_0000_0003, 33, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE);
        run("uw100/7", 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0064, 64'h0000_ABCD_0000_0007, 33, 64'd14, 64'd2);

        // Held request: accepted, DONE does not accept, next IDLE edge accepts new operands
        divw = 1'b0; div_signed = 1'b0; dividend = 64'd5; divisor = 64'd0; div_valid = 1'b1;
        step();
        chk("b2b first", 64'(out_valid), 64'd1);
        dividend = 64'd9;
        step();
        chk("b2b idle valid", 64'(out_valid), 64'd0);
        chk("b2b idle ready", 64'(div_ready), 64'd1);
        step();
        chk("b2b second", 64'(out_valid), 64'd1);
        chk("b2b second r", remainder, 64'd9);
        div_valid = 1'b0;
        step();

        // Flush and valid together in IDLE must not accept
        dividend = 64'd5; divisor = 64'd0; div_valid = 1'b1; flush = 1'b1;
        step();
        div_valid = 1'b0; flush = 1'b0;
        chk("flush_idle valid", 64'(out_valid), 64'd0);
        chk("flush_idle ready", 64'(div_ready), 64'd1);

        // Flush in cycle 10 of a 64-bit op
        dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        repeat (9) step();
        chk("flush c10 ready", 64'(div_ready), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush c11 ready", 64'(div_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("flush no valid", 64'(seen), 64'd0);

        // Reset in cycle 10 of a 64-bit op
        dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        repeat (9) step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst ready", 64'(div_ready), 64'd1);
        chk("mid_rst valid", 64'(out_valid), 64'd0);
        chk("mid_rst q", quotient, 64'd0);
        chk("mid_rst r", remainder, 64'd0);
        step();
        rst = 1'b1;
        run("recover9/3", 1'b0, 1'b0, 64'd9, 64'd3, 65, 64'd3, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
